// File: rtl/uart_mouse_transmitter.sv
// uart_mouse_transmitter: serialises a mouse sample into the 6-byte 8N1 UART mouse packet.
// Define UART_MOUSE_TX_CHECKSUM_EN to append a 7th byte holding the XOR of bytes 1..5.
module uart_mouse_transmitter #(
    parameter int FREQ_HZ  = 27000000,
    parameter int BAUD     = 115200,
    parameter int GAP_BITS = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [2:0] buttons,
    input  logic       send,
    output logic       ready,
    output logic       uart_txd,
    output logic       packet_sent,
    output logic [3:0] led
);
    localparam int DIV = FREQ_HZ / BAUD;
    localparam int CW  = $clog2(16 * DIV);
`ifdef UART_MOUSE_TX_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam logic [2:0]    LAST    = 3'(NB - 1);
    localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP_BITS * DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      byte_idx;
    logic [8*NB-1:0] payload;
    logic [8*NB-1:0] frame;
    logic [47:0]     base;
    logic [1:0]      btn_l;
    logic [1:0]      led_btn;
    logic            led_tog;
    logic            tick;
    logic            finish;

    // Byte 0 sits in the LSBs so a plain right shift yields byte order and LSB-first bits.
    assign base = {5'b0, buttons, 7'b0, mouse_y[8], mouse_y[7:0], 7'b0, mouse_x[8], mouse_x[7:0], 8'hAA};
`ifdef UART_MOUSE_TX_CHECKSUM_EN
    assign frame = {base[15:8] ^ base[23:16] ^ base[31:24] ^ base[39:32] ^ base[47:40], base};
`else
    assign frame = base;
`endif

    assign tick   = (cnt == BIT_END) && (state != GAP);
    assign finish = (state == STOP && tick && byte_idx == LAST && GAP_BITS == 0) ||
                    (state == GAP && cnt == GAP_END);
    assign led    = {led_btn, led_tog, ~ready};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            payload     <= '0;
            btn_l       <= '0;
            led_btn     <= '0;
            led_tog     <= 1'b0;
            uart_txd    <= 1'b1;
            ready       <= 1'b1;
            packet_sent <= 1'b0;
        end else begin
            packet_sent <= finish;
            cnt         <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            if (finish) begin
                state    <= IDLE;
                ready    <= 1'b1;
                uart_txd <= 1'b1;
                led_tog  <= ~led_tog;
                led_btn  <= btn_l;
            end else begin
                case (state)
                    IDLE: if (send) begin
                        state    <= START;
                        ready    <= 1'b0;
                        uart_txd <= 1'b0;
                        payload  <= frame;
                        btn_l    <= buttons[1:0];
                        byte_idx <= '0;
                    end
                    START: if (tick) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        uart_txd <= payload[0];
                        payload  <= payload >> 1;
                    end
                    DATA: if (tick) begin
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= payload[0];
                            payload  <= payload >> 1;
                        end
                    end
                    STOP: if (tick) begin
                        if (byte_idx != LAST) begin
                            state    <= START;
                            byte_idx <= byte_idx + 3'd1;
                            uart_txd <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_mouse_transmitter.sv
// tb_uart_mouse_transmitter: randomized and directed checks of the UART mouse packet serialiser
// against a per-cycle line model built from the packet format; a second instance covers the idle gap.
module tb_uart_mouse_transmitter;
    localparam int FREQ = 1000000;
    localparam int BAUD = 83000;
    localparam int DIV  = FREQ / BAUD;
    localparam int GAPB = 3;
`ifdef UART_MOUSE_TX_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int PLEN = NB * 10 * DIV;

    logic       clk;
    logic       rst_n;
    logic [8:0] mouse_x;
    logic [8:0] mouse_y;
    logic [2:0] buttons;
    logic       send;
    logic       ready0, txd0, ps0;
    logic [3:0] led0;
    logic       ready1, txd1, ps1;
    logic [3:0] led1;

    int   checks;
    int   errors;
    logic exp_tog;

    uart_mouse_transmitter #(.FREQ_HZ(FREQ), .BAUD(BAUD), .GAP_BITS(0)) dut (
        .clk(clk), .rst_n(rst_n), .mouse_x(mouse_x), .mouse_y(mouse_y), .buttons(buttons),
        .send(send), .ready(ready0), .uart_txd(txd0), .packet_sent(ps0), .led(led0)
    );

    uart_mouse_transmitter #(.FREQ_HZ(FREQ), .BAUD(BAUD), .GAP_BITS(GAPB)) dut_gap (
        .clk(clk), .rst_n(rst_n), .mouse_x(mouse_x), .mouse_y(mouse_y), .buttons(buttons),
        .send(send), .ready(ready1), .uart_txd(txd1), .packet_sent(ps1), .led(led1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(int i, logic [8:0] x, logic [8:0] y, logic [2:0] b);
        case (i)
            0: return 8'hAA;
            1: return x[7:0];
            2: return {7'b0, x[8]};
            3: return y[7:0];
            4: return {7'b0, y[8]};
            5: return {5'b0, b};
            default: return x[7:0] ^ {7'b0, x[8]} ^ y[7:0] ^ {7'b0, y[8]} ^ {5'b0, b};
        endcase
    endfunction

    // Line level k cycles after the accept edge: start, 8 data LSB first, stop, then idle mark.
    function automatic logic exp_txd(int k, logic [8:0] x, logic [8:0] y, logic [2:0] b);
        int n = k / DIV;
        int by = n / 10;
        int pos = n % 10;
        logic [7:0] v;
        if (by >= NB) return 1'b1;
        v = exp_byte(by, x, y, b);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return v[pos-1];
    endfunction

    task automatic run_packet(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b,
                              input bit hold, input int pulse_at, input string name);
        int   bad_line = 0;
        int   bad_busy = 0;
        int   first_k = -1;
        logic first_act = 1'b0;
        logic first_exp = 1'b0;
        mouse_x = x;
        mouse_y = y;
        buttons = b;
        send    = 1'b1;
        checks++;
        if (ready0 !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, ready0);
        end
        @(posedge clk);
        for (int k = 0; k < PLEN; k++) begin
            @(negedge clk);
            if (k == 0) begin
                send    = hold;
                mouse_x = 9'($urandom);
                mouse_y = 9'($urandom);
                buttons = 3'($urandom);
            end
            if (!hold && k == pulse_at) send = 1'b1;
            if (!hold && k == pulse_at + 1) send = 1'b0;
            if (txd0 !== exp_txd(k, x, y, b)) begin
                if (bad_line == 0) begin
                    first_k   = k;
                    first_act = txd0;
                    first_exp = exp_txd(k, x, y, b);
                end
                bad_line++;
            end
            if (ready0 !== 1'b0 || ps0 !== 1'b0 || led0[0] !== 1'b1) bad_busy++;
        end
        @(negedge clk);
        checks++;
        if (bad_line != 0) begin
            errors++;
            $display("FAIL %s line: %0d bad cycles, first at cycle %0d got %b want %b",
                     name, bad_line, first_k, first_act, first_exp);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL %s busy_flags: %0d cycles with ready/packet_sent/led0 wrong, want 0", name, bad_busy);
        end
        checks++;
        if (ps0 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL %s sent_timing: packet_sent=%b ready=%b at cycle %0d, want 1 1", name, ps0, ready0, PLEN);
        end
        exp_tog = ~exp_tog;
        checks++;
        if (led0 !== {b[1:0], exp_tog, 1'b0}) begin
            errors++;
            $display("FAIL %s led: got %b want %b", name, led0, {b[1:0], exp_tog, 1'b0});
        end
    endtask

    task automatic check_pulse_end(input string name);
        @(negedge clk);
        checks++;
        if (ps0 !== 1'b0 || ready0 !== 1'b1 || txd0 !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse_end: packet_sent=%b ready=%b txd=%b want 0 1 1", name, ps0, ready0, txd0);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n   = 1'b0;
        send    = 1'b0;
        mouse_x = '0;
        mouse_y = '0;
        buttons = '0;
        exp_tog = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (txd0 !== 1'b1 || ready0 !== 1'b1 || ps0 !== 1'b0 || led0 !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: txd=%b ready=%b ps=%b led=%b want 1 1 0 0000", txd0, ready0, ps0, led0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || ready0 !== 1'b1 || ps0 !== 1'b0 || txd1 !== 1'b1 || ready1 !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d cycles not idle, want 0", bad);
        end
    endtask

    task automatic test_gap();
        int p0 = -1;
        int p1 = -1;
        int bad = 0;
        logic [8:0] x = 9'($urandom);
        logic [8:0] y = 9'($urandom);
        logic [2:0] b = 3'($urandom);
        mouse_x = x;
        mouse_y = y;
        buttons = b;
        send    = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3 * PLEN && p1 < 0; k++) begin
            @(negedge clk);
            if (k == 0) send = 1'b0;
            if (ps0 === 1'b1) p0 = k;
            if (ps1 === 1'b1) p1 = k;
            else if (txd1 !== exp_txd(k, x, y, b) || ready1 !== 1'b0) bad++;
        end
        exp_tog = ~exp_tog;
        checks++;
        if (p0 != PLEN) begin
            errors++;
            $display("FAIL gap0_timing: packet_sent at %0d want %0d", p0, PLEN);
        end
        checks++;
        if (p1 != PLEN + GAPB * DIV) begin
            errors++;
            $display("FAIL gap_timing: packet_sent at %0d want %0d", p1, PLEN + GAPB * DIV);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gap_line: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_vectors();
        run_packet(9'd10, 9'd0, 3'b000, 1'b0, -10, "x10");
        check_pulse_end("x10");
        run_packet(9'h1F1, 9'h100, 3'b111, 1'b0, -10, "neg");
        check_pulse_end("neg");
        run_packet(9'd0, 9'd0, 3'b000, 1'b0, -10, "zero");
        run_packet(9'd255, 9'd255, 3'b000, 1'b0, -10, "max");
        run_packet(9'h19C, 9'd100, 3'b000, 1'b0, -10, "m100");
        run_packet(9'd5, 9'h1F8, 3'b111, 1'b0, -10, "m8");
        for (int i = 0; i < 3; i++)
            run_packet(9'($urandom), 9'($urandom), 3'($urandom), 1'b0, -10, "rand");
        check_pulse_end("rand");
    endtask

    task automatic test_back_to_back();
        run_packet(9'($urandom), 9'($urandom), 3'($urandom), 1'b1, -10, "b2b0");
        run_packet(9'($urandom), 9'($urandom), 3'($urandom), 1'b1, -10, "b2b1");
        run_packet(9'($urandom), 9'($urandom), 3'($urandom), 1'b0, -10, "b2b2");
        check_pulse_end("b2b2");
    endtask

    task automatic test_ignore();
        int bad = 0;
        run_packet(9'($urandom), 9'($urandom), 3'($urandom), 1'b0, 5 * DIV + 3, "ignore");
        for (int k = 0; k < 3 * DIV; k++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || ready0 !== 1'b1 || ps0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_no_extra: %0d non-idle cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        mouse_x = 9'h0F0;
        mouse_y = 9'h1AB;
        buttons = 3'b101;
        send    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send = 1'b0;
        repeat (24 * DIV + DIV / 2) @(negedge clk);
        checks++;
        if (ready0 !== 1'b0 || txd0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_before_reset: ready=%b txd=%b want 0 0", ready0, txd0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txd0 !== 1'b1 || ready0 !== 1'b1 || led0 !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_async: txd=%b ready=%b led=%b want 1 1 0000", txd0, ready0, led0);
        end
        exp_tog = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (txd0 !== 1'b1 || ready0 !== 1'b1 || ps0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: txd=%b ready=%b ps=%b want 1 1 0", txd0, ready0, ps0);
        end
        run_packet(9'($urandom), 9'($urandom), 3'($urandom), 1'b0, -10, "after_reset");
        check_pulse_end("after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_gap();
        test_vectors();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
